riot_host_arbiter: RTL
======================

RIOT_HOST_ARBITER -- requirements
Module: riot_host_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, 8-bit count of blocked ce cycles before a host request is abandoned (used only with RIOT_ARB_TIMEOUT_EN).
REQ-002 SHALL have ports: clk  in  1  PHI2 clock; res_n  in  1  reset; one clock, reset asynchronous active-low.
REQ-003 ce  in  1  clock enable, the cycle on which the RIOT samples its bus.
REQ-004 cpu_sel  in  1  CPU decode selects the RIOT this ce; cpu_addr  in  7; cpu_rw_n  in  1; cpu_rs_n  in  1; cpu_din  in  8.
REQ-005 cpu_dout  out  8  read data to the CPU.
REQ-006 host_req  in  1  host request, active on rising edge; host_addr  in  7; host_rs_n  in  1; host_we  in  1; host_wdata  in  8.
REQ-007 host_ack  out  1  one-cycle completion pulse; host_rdata  out  8; host_err  out  1  timeout flag, valid with host_ack; busy  out  1.
REQ-008 riot_addr  out  7; riot_rw_n  out  1; riot_rs_n  out  1; riot_din  out  8; riot_cs1  out  1; riot_cs2_n  out  1; riot_dout  in  8.

Function
REQ-009 SHALL implement states IDLE, WAIT and CAPTURE; busy SHALL be 1 whenever state != IDLE.
REQ-010 SHALL register host_req each clk and detect a request on a 0->1 transition; the transition SHALL be acted on only in IDLE.
REQ-011 On request in IDLE, SHALL latch host_addr/rs_n/we/wdata and enter WAIT at that edge; a rising edge outside IDLE SHALL be dropped silently.
REQ-012 CPU SHALL have absolute priority: when cpu_sel=1, riot_* SHALL carry cpu_addr, cpu_rw_n, cpu_rs_n, cpu_din, with cs1=1 and cs2_n=0, combinationally.
REQ-013 In WAIT with cpu_sel=0, riot_* SHALL carry the latched host fields (rw_n = ~we), with cs1=1 and cs2_n=0. The edge on which ce=1 in this condition SHALL be the issue edge E, and the state SHALL become CAPTURE.
REQ-014 Otherwise riot_cs1=0, riot_cs2_n=1, riot_rw_n=1, and riot_addr/rs_n/din SHALL hold the last latched host values.
REQ-015 On the edge after E (E+1), CAPTURE SHALL go to IDLE, with host_ack<=1 and host_err<=0. For a read, host_rdata<=riot_dout; for a write, host_rdata SHALL be unchanged.
REQ-016 host_ack SHALL clear on the next edge, giving exactly one cycle high; the host read latency SHALL be 2 clk after E.
REQ-017 cpu_dout SHALL equal riot_dout combinationally.
REQ-018 A request edge coincident with an idle ce SHALL NOT issue on that ce; the earliest issue SHALL be the next ce.
REQ-019 Host accesses SHALL NOT be filtered: timer-read and flag-read side effects in the RIOT occur as for a CPU access.

Reset
REQ-020 On res_n=0, asynchronously: state=IDLE, host_ack=0, host_err=0, host_rdata=8'h00, latched host fields=0, registered host_req=0, timeout counter=0.
REQ-021 A reset during WAIT or CAPTURE SHALL abandon the request with no ack. A host_req already high at reset release SHALL NOT count as a rising edge.

Configuration
REQ-022 With macro RIOT_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on WAIT entry and increment on each ce in WAIT with cpu_sel=1.
REQ-023 With RIOT_ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES on such a ce: state SHALL go to IDLE, host_ack=1, host_err=1, host_rdata=8'hFF, and no RIOT access SHALL be issued.
REQ-024 Without RIOT_ARB_TIMEOUT_EN, the counter SHALL be absent, host_err SHALL be constant 0, WAIT SHALL persist indefinitely, and TIMEOUT_CYCLES SHALL be ignored.

Verification
REQ-025 Host read, no CPU traffic: host_addr=7'h04, rs_n=0, RIOT RAM[4]=8'h85, ce every 2 clk -> one issue ce, then host_ack one cycle with host_rdata=8'h85 2 clk after E.
REQ-026 Contention: cpu_sel=1 on the next 3 ce while host write 8'h3C to RAM 7'h10 pending -> CPU accesses drive the RIOT unchanged; host write issues on the 4th ce; a later read returns 8'h3C.
REQ-027 Second host_req edge while busy=1 -> ignored: exactly one ack, and the latched address is unchanged.
REQ-028 Reset asserted in CAPTURE -> host_ack never pulses and busy=0 immediately; after release with host_req held high, no access is issued.
REQ-029 RIOT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=3, cpu_sel=1 on every ce -> on the 4th blocked ce, host_ack=1, host_err=1, host_rdata=8'hFF, and riot_cs1 is never driven for the host.
REQ-030 Host read of addr 7'h04 with rs_n=1 (timer) after the timer underflows -> host_rdata is the timer value and RIOT interrupt flag behaviour matches a CPU read.

Source files
------------

// File: rtl/riot_host_arbiter.sv
// rtl/riot_host_arbiter.sv - shares one RIOT between the 6502 bus (priority) and a host port
// Optional abandon-on-timeout of blocked host requests: define RIOT_ARB_TIMEOUT_EN.
module riot_host_arbiter #(
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       ce,
   input  logic       cpu_sel,
   input  logic [6:0] cpu_addr,
   input  logic       cpu_rw_n,
   input  logic       cpu_rs_n,
   input  logic [7:0] cpu_din,
   output logic [7:0] cpu_dout,
   input  logic       host_req,
   input  logic [6:0] host_addr,
   input  logic       host_rs_n,
   input  logic       host_we,
   input  logic [7:0] host_wdata,
   output logic       host_ack,
   output logic [7:0] host_rdata,
   output logic       host_err,
   output logic       busy,
   output logic [6:0] riot_addr,
   output logic       riot_rw_n,
   output logic       riot_rs_n,
   output logic [7:0] riot_din,
   output logic       riot_cs1,
   output logic       riot_cs2_n,
   input  logic [7:0] riot_dout
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;

   logic [1:0] state_q, state_d;
   logic       req_q, arm_q;
   logic [6:0] addr_q, addr_d;
   logic       rs_n_q, rs_n_d, we_q, we_d;
   logic [7:0] wdata_q, wdata_d;
   logic       ack_q, ack_d;
   logic [7:0] rdata_q, rdata_d;
   logic       req_rise;

   // arm_q masks the first edge after reset so a request held high through reset is not an edge
   assign req_rise = host_req & ~req_q & arm_q;

`ifdef RIOT_ARB_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   assign host_err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign host_err       = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rs_n_d  = rs_n_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      ack_d   = 1'b0;
      rdata_d = rdata_q;
`ifdef RIOT_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_rise) begin
               state_d = S_WAIT;
               addr_d  = host_addr;
               rs_n_d  = host_rs_n;
               we_d    = host_we;
               wdata_d = host_wdata;
`ifdef RIOT_ARB_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end
         end
         S_WAIT: begin
            if (ce && !cpu_sel) begin
               state_d = S_CAPTURE;
            end
`ifdef RIOT_ARB_TIMEOUT_EN
            else if (ce && cpu_sel) begin
               if (cnt_q == TIMEOUT_CYCLES) begin
                  state_d = S_IDLE;
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = 8'hFF;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
`endif
         end
         S_CAPTURE: begin
            state_d = S_IDLE;
            ack_d   = 1'b1;
`ifdef RIOT_ARB_TIMEOUT_EN
            err_d   = 1'b0;
`endif
            if (!we_q) rdata_d = riot_dout;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         arm_q   <= 1'b0;
         addr_q  <= 7'h00;
         rs_n_q  <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= 8'h00;
         ack_q   <= 1'b0;
         rdata_q <= 8'h00;
`ifdef RIOT_ARB_TIMEOUT_EN
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= host_req;
         arm_q   <= 1'b1;
         addr_q  <= addr_d;
         rs_n_q  <= rs_n_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
`ifdef RIOT_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   // The CPU always wins the bus; the host only drives chip selects while waiting for a free ce
   always_comb begin
      riot_addr  = addr_q;
      riot_rs_n  = rs_n_q;
      riot_din   = wdata_q;
      riot_rw_n  = 1'b1;
      riot_cs1   = 1'b0;
      riot_cs2_n = 1'b1;
      if (cpu_sel) begin
         riot_addr  = cpu_addr;
         riot_rs_n  = cpu_rs_n;
         riot_din   = cpu_din;
         riot_rw_n  = cpu_rw_n;
         riot_cs1   = 1'b1;
         riot_cs2_n = 1'b0;
      end else if (state_q == S_WAIT) begin
         riot_rw_n  = ~we_q;
         riot_cs1   = 1'b1;
         riot_cs2_n = 1'b0;
      end
   end

   assign cpu_dout   = riot_dout;
   assign host_ack   = ack_q;
   assign host_rdata = rdata_q;
   assign busy       = (state_q != S_IDLE);

endmodule
